// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the pipelined ALU: the 3-bit opcode map, the packed status
// flag struct and the flag vector width.
//   alu_op_e    : opcode encoding (ADD, SUB, AND, OR, XOR, SLL, SRL, SLT)
//   alu_flags_t : {carry, overflow, negative, zero}, MSB first
//   FLAG_W      : width of alu_flags_t
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int FLAG_W = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SLL = 3'd5,
      OP_SRL = 3'd6,
      OP_SLT = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic negative;
      logic zero;
   } alu_flags_t;

endpackage

// File: rtl/alu_pipe_slice.sv
// -----------------------------------------------------------------------------
// alu_pipe_slice
// One valid/ready register slice carrying a W-bit payload.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1 on the same side; ready_o = !valid_q || ready_i, so a full slice still
// accepts whenever its content leaves downstream on the same edge.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   valid_i   : upstream payload valid
//   ready_o   : slice can take a payload this cycle
//   data_i    : upstream payload
//   valid_o   : slice holds a payload
//   ready_i   : downstream takes the payload this cycle
//   data_o    : held payload (cleared by reset, otherwise holds last value)
// -----------------------------------------------------------------------------
module alu_pipe_slice #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   assign ready_o = !valid_q || ready_i;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (ready_o) begin
         valid_d = valid_i;
         // Only overwrite the payload on a real transfer so an emptied slice
         // keeps showing its last result.
         if (valid_i) data_d = data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Pipelined ALU: the operation is evaluated combinationally on the accepted
// operands, then {result, flags} travel through STAGES valid/ready slices.
// Full throughput, backpressure via out_ready, in-order, no drops.
// Parameters: WIDTH (>=4, power of two), STAGES (>=1).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : input handshake (in_ready = first slice's ready)
//   A, B, opcode      : operands and alu_op_e opcode; shifts use B[log2 W-1:0]
//   out_valid/out_ready : output handshake
//   result, flags     : result and {carry, overflow, negative, zero}
// Build option: define ALU_PIPE_SAT_EN to saturate ADD/SUB on signed overflow
// (overflow flag still set, carry unchanged); otherwise ADD/SUB wrap.
// -----------------------------------------------------------------------------
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int SHW = $clog2(WIDTH);
   localparam int PW  = WIDTH + FLAG_W;

   alu_op_e          op;
   logic             cin;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             ovf;
   logic             lt;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] res;
   alu_flags_t       fl;

   // ---------------- combinational ALU ----------------
   always_comb begin
      op    = alu_op_e'(opcode);
      shamt = B[SHW-1:0];
      // SUB is A + ~B + 1 so carry-out means "no borrow".
      cin   = (op == OP_SUB);
      b_eff = cin ? ~B : B;
      sum   = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
      // Signed overflow: operands agree in sign, sum disagrees.
      ovf   = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      lt    = $signed(A) < $signed(B);
      res   = '0;
      fl    = '0;
      case (op)
         OP_ADD, OP_SUB: begin
            res         = sum[WIDTH-1:0];
            fl.carry    = sum[WIDTH];
            fl.overflow = ovf;
`ifdef ALU_PIPE_SAT_EN
            // On overflow the wrapped sign is the inverse of the true sign.
            if (ovf) begin
               res = sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                  : {1'b1, {(WIDTH-1){1'b0}}};
            end
`endif
         end
         OP_AND: res = A & B;
         OP_OR:  res = A | B;
         OP_XOR: res = A ^ B;
         OP_SLL: res = A << shamt;
         OP_SRL: res = A >> shamt;
         OP_SLT: res = {{(WIDTH-1){1'b0}}, lt};
      endcase
      fl.negative = res[WIDTH-1];
      fl.zero     = (res == '0);
   end

   // ---------------- slice chain ----------------
   logic          vld [STAGES+1];
   logic          rdy [STAGES+1];
   logic [PW-1:0] pay [STAGES+1];

   assign vld[0]      = in_valid;
   assign pay[0]      = {res, fl};
   assign rdy[STAGES] = out_ready;

   for (genvar i = 0; i < STAGES; i++) begin : g_slice
      alu_pipe_slice #(.W(PW)) u_slice (
         .clk     (clk),
         .rst     (rst),
         .valid_i (vld[i]),
         .ready_o (rdy[i]),
         .data_i  (pay[i]),
         .valid_o (vld[i+1]),
         .ready_i (rdy[i+1]),
         .data_o  (pay[i+1])
      );
   end

   assign in_ready        = rdy[0];
   assign out_valid       = vld[STAGES];
   assign {result, flags} = pay[STAGES];

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Bench for alu_pipe: a WIDTH=32/STAGES=2 instance driven through a scoreboard
// (expected {result,flags} queued on input transfer, compared on output
// transfer) plus a WIDTH=8/STAGES=1 instance checked directly.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- DUT 32/2 ----------------
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic [31:0] A = '0, B = '0, result;
   logic [2:0]  opcode = '0;
   logic [3:0]  flags;

   alu_pipe #(.WIDTH(32), .STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .opcode(opcode), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .flags(flags)
   );

   // ---------------- DUT 8/1 ----------------
   logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
   logic [7:0] a8 = '0, b8 = '0, result8;
   logic [2:0] opcode8 = '0;
   logic [3:0] flags8;

   alu_pipe #(.WIDTH(8), .STAGES(1)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .A(a8), .B(b8), .opcode(opcode8), .out_valid(out_valid8),
      .out_ready(out_ready8), .result(result8), .flags(flags8)
   );

   // ---------------- checking ----------------
   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: returns {res[31:0], carry, overflow, negative, zero}
   // for a w-bit ALU (w <= 32), built from masked wide arithmetic.
   function automatic logic [35:0] model(input int w, input logic [2:0] op,
                                         input logic [31:0] a_in, input logic [31:0] b_in);
      logic [31:0] mask, sign, a, b, res;
      logic [63:0] full;
      logic        c, ov;
      int          sh;
      longint      sa, sb;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      sign = 32'd1 << (w - 1);
      a = a_in & mask;
      b = b_in & mask;
      c = 1'b0; ov = 1'b0; res = '0; full = '0;
      sh = int'(b) & (w - 1);
      case (op)
         3'd0: begin
            full = {32'd0, a} + {32'd0, b};
            res  = full[31:0] & mask;
            c    = full[w];
            ov   = ((a & sign) == (b & sign)) && ((res & sign) != (a & sign));
         end
         3'd1: begin
            full = {32'd0, a} + {32'd0, (~b) & mask} + 64'd1;
            res  = full[31:0] & mask;
            c    = full[w];
            ov   = ((a & sign) != (b & sign)) && ((res & sign) != (a & sign));
         end
         3'd2: res = a & b;
         3'd3: res = a | b;
         3'd4: res = a ^ b;
         3'd5: res = (a << sh) & mask;
         3'd6: res = a >> sh;
         default: begin
            sa  = longint'(a) - (((a & sign) != 0) ? (longint'(1) << w) : longint'(0));
            sb  = longint'(b) - (((b & sign) != 0) ? (longint'(1) << w) : longint'(0));
            res = (sa < sb) ? 32'd1 : 32'd0;
         end
      endcase
`ifdef ALU_PIPE_SAT_EN
      // The true result has the sign of A whenever ADD/SUB overflows.
      if ((op == 3'd0 || op == 3'd1) && ov) res = ((a & sign) != 0) ? sign : (sign - 32'd1);
`endif
      return {res, c, ov, ((res & sign) != 0), (res == 0)};
   endfunction

   // ---------------- scoreboard ----------------
   logic [35:0] exp_q[$];
   int          out_cyc[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("sb_extra_output", 1, 0);
            else check("sb_result", {result, flags}, exp_q.pop_front());
         end
         if (in_valid && in_ready) exp_q.push_back(model(32, opcode, A, B));
      end
   end

   // Random backpressure generator, enabled only in the random phase.
   logic rand_bp = 1'b0;
   always @(posedge clk) begin
      if (rand_bp) begin
         #1 out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1; returns at posedge+1 just after the transfer edge.
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int guard = 0;
      in_valid = 1'b1; opcode = op; A = a; B = b;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) check("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Single op on the 32-bit DUT with out_ready=1: checks the latency and the
   // presented value against a constant.
   task automatic single32(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [35:0] exp);
      in_valid = 1'b1; opcode = op; A = a; B = b;
      @(negedge clk);
      check({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_lat_early"}, out_valid, 0);
      @(negedge clk);
      check({tag, "_lat_valid"}, out_valid, 1);
      check({tag, "_value"}, {result, flags}, exp);
      @(posedge clk); #1;
   endtask

   task automatic single8(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b);
      logic [35:0] e;
      e = model(8, op, {24'd0, a}, {24'd0, b});
      in_valid8 = 1'b1; opcode8 = op; a8 = a; b8 = b;
      @(negedge clk);
      check({tag, "_in_ready"}, in_ready8, 1);
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      @(negedge clk);
      check({tag, "_valid"}, out_valid8, 1);
      check({tag, "_value"}, {24'd0, result8, flags8}, e);
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   logic [2:0]  s_op [8] = '{3'd5, 3'd6, 3'd7, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
   logic [31:0] s_a  [8] = '{32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'hF0F0_1234,
                             32'h0F00_00A0, 32'hAAAA_5555, 32'h7FFF_FFFF, 32'h5};
   logic [31:0] s_b  [8] = '{32'd31, 32'd35, 32'h0, 32'hFF00_FF0F,
                             32'h0000_0F05, 32'hFFFF_0000, 32'h1, 32'h7};

   initial begin
      int t0;
      int guard;
      logic [31:0] ra, rb;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_flags", flags, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // ADD wrap to zero with carry
      single32("t1_add", 3'd0, 32'hFFFF_FFFF, 32'h1, {32'h0, 4'b1001});

      // SUB signed overflow
`ifdef ALU_PIPE_SAT_EN
      single32("t2_sub", 3'd1, 32'h8000_0000, 32'h1, {32'h8000_0000, 4'b1110});
`else
      single32("t2_sub", 3'd1, 32'h8000_0000, 32'h1, {32'h7FFF_FFFF, 4'b1100});
`endif

      // Back-to-back stream of 8
      out_cyc.delete();
      t0 = cyc;
      for (int i = 0; i < 8; i++) send(s_op[i], s_a[i], s_b[i]);
      check("t3_no_input_stall", cyc - t0, 8);
      repeat (4) @(negedge clk);
      check("t3_out_count", out_cyc.size(), 8);
      if (out_cyc.size() == 8) check("t3_consecutive", out_cyc[7] - out_cyc[0], 7);
      @(posedge clk); #1;

      // Backpressure: fill, stall, release with a simultaneous accept/retire
      out_ready = 1'b0;
      send(3'd0, 32'h1234_5678, 32'h1111_1111);
      send(3'd4, 32'hDEAD_BEEF, 32'hFFFF_0000);
      in_valid = 1'b1; opcode = 3'd1; A = 32'h10; B = 32'h20;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_full_in_ready", in_ready, 0);
         check("t4_stall_valid", out_valid, 1);
         if (exp_q.size() > 0) check("t4_stall_hold", {result, flags}, exp_q[0]);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("t4_simul_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("t4_drained", exp_q.size(), 0);
      @(posedge clk); #1;

      // Asynchronous reset with 2 ops in flight
      send(3'd3, 32'h0000_00F0, 32'h0000_000F);
      send(3'd0, 32'h2, 32'h3);
      #1 rst = 1'b1;
      #1;
      check("t5_rst_out_valid", out_valid, 0);
      check("t5_rst_result", result, 0);
      check("t5_rst_flags", flags, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(negedge clk);
      check("t5_in_ready", in_ready, 1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t5_no_stale", out_valid, 0);
      end
      @(posedge clk); #1;

      // WIDTH=8, STAGES=1
`ifdef ALU_PIPE_SAT_EN
      single8("t6_add_ovf", 3'd0, 8'h7F, 8'h01);
      check("t6_add_const", {result8, flags8}, {8'h7F, 4'b0100});
`else
      single8("t6_add_ovf", 3'd0, 8'h7F, 8'h01);
      check("t6_add_const", {result8, flags8}, {8'h80, 4'b0110});
`endif
      single8("t6_sub_borrow", 3'd1, 8'h00, 8'h01);
      single8("t6_sll_mod", 3'd5, 8'h01, 8'h09);
      single8("t6_slt", 3'd7, 8'h80, 8'h01);

      // Random ops with random backpressure
      rand_bp = 1'b1;
      for (int i = 0; i < 60; i++) begin
         ra = $urandom();
         rb = $urandom();
         case ($urandom_range(0, 3))
            0: ra = 32'h7FFF_FFFF;
            1: rb = 32'h8000_0000;
            default: ;
         endcase
         send(3'($urandom_range(0, 7)), ra, rb);
      end
      rand_bp = 1'b0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("final_drain", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      check("watchdog", 0, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
